// File: rtl/bus_arbiter_if.sv
// Signal bundle shared by the two bus masters, the arbiter and the slave bus.
// The master modport is the view of the requesters; the slave modport is the arbiter's view.
interface bus_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_grant;
    logic        m1_grant;
    logic [29:0] m0_address;
    logic [29:0] m1_address;
    logic [31:0] m0_data_out;
    logic [31:0] m1_data_out;
    logic [3:0]  m0_data_strobes;
    logic [3:0]  m1_data_strobes;
    logic        m0_read;
    logic        m0_write;
    logic        m1_read;
    logic        m1_write;
    logic        m0_bus_error;
    logic        m1_bus_error;
    logic [29:0] address;
    logic [31:0] data_out;
    logic [3:0]  data_strobes;
    logic        read;
    logic        write;
    logic        memory_cs;
    logic        display_cs;

    modport master (
        output m0_req, m1_req,
        output m0_address, m1_address,
        output m0_data_out, m1_data_out,
        output m0_data_strobes, m1_data_strobes,
        output m0_read, m0_write, m1_read, m1_write,
        input  m0_grant, m1_grant,
        input  m0_bus_error, m1_bus_error,
        input  address, data_out, data_strobes,
        input  read, write, memory_cs, display_cs
    );

    modport slave (
        input  m0_req, m1_req,
        input  m0_address, m1_address,
        input  m0_data_out, m1_data_out,
        input  m0_data_strobes, m1_data_strobes,
        input  m0_read, m0_write, m1_read, m1_write,
        output m0_grant, m1_grant,
        output m0_bus_error, m1_bus_error,
        output address, data_out, data_strobes,
        output read, write, memory_cs, display_cs
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master arbiter with burst-limited preemption, slave-bus mux and address decode.
// Define BUS_ARBITER_ROUND_ROBIN_EN to break IDLE ties in favour of the less recent owner.
module bus_arbiter #(
    parameter int MAX_BURST = 8
) (
    input logic          clock,
    input logic          reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t      state;
    state_t      state_next;
    logic [7:0]  burst_count;
    logic [7:0]  burst_count_next;
    logic [29:0] sel_address;
    logic [31:0] sel_data;
    logic [3:0]  sel_strobes;
    logic        sel_read;
    logic        sel_write;
    logic [7:0]  region;
    logic        granted;
    logic        unmapped;
    logic        m0_error;
    logic        m1_error;

`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    logic last_owner;

    // 1 means m1 owned the bus most recently, so m0 wins the first tie
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_owner <= 1'b1;
        end else if (state == OWN0) begin
            last_owner <= 1'b0;
        end else if (state == OWN1) begin
            last_owner <= 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            burst_count <= '0;
        end else begin
            state       <= state_next;
            burst_count <= burst_count_next;
        end
    end

    always_comb begin
        state_next       = state;
        burst_count_next = '0;
        case (state)
            IDLE: begin
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
                if (bus.m0_req && bus.m1_req) begin
                    state_next = last_owner ? OWN0 : OWN1;
                end else if (bus.m0_req) begin
                    state_next = OWN0;
                end else if (bus.m1_req) begin
                    state_next = OWN1;
                end
`else
                if (bus.m0_req) begin
                    state_next = OWN0;
                end else if (bus.m1_req) begin
                    state_next = OWN1;
                end
`endif
            end
            OWN0: begin
                if (!bus.m0_req) begin
                    state_next = bus.m1_req ? OWN1 : IDLE;
                end else if (bus.m1_req) begin
                    // Contested: count held cycles and hand over after the last one
                    if (burst_count == BURST_LAST) begin
                        state_next = OWN1;
                    end else begin
                        burst_count_next = burst_count + 8'd1;
                    end
                end
            end
            OWN1: begin
                if (!bus.m1_req) begin
                    state_next = bus.m0_req ? OWN0 : IDLE;
                end else if (bus.m0_req) begin
                    if (burst_count == BURST_LAST) begin
                        state_next = OWN0;
                    end else begin
                        burst_count_next = burst_count + 8'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_address = '0;
        sel_data    = '0;
        sel_strobes = '0;
        sel_read    = 1'b0;
        sel_write   = 1'b0;
        case (state)
            OWN0: begin
                sel_address = bus.m0_address;
                sel_data    = bus.m0_data_out;
                sel_strobes = bus.m0_data_strobes;
                sel_read    = bus.m0_read;
                sel_write   = bus.m0_write;
            end
            OWN1: begin
                sel_address = bus.m1_address;
                sel_data    = bus.m1_data_out;
                sel_strobes = bus.m1_data_strobes;
                sel_read    = bus.m1_read;
                sel_write   = bus.m1_write;
            end
            default: ;
        endcase
    end

    // Word address bits [29:22] are byte address bits [31:24]
    assign region   = sel_address[29:22];
    assign granted  = (state != IDLE);
    assign unmapped = (region != 8'h00) && (region != 8'hFF);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m0_error <= 1'b0;
            m1_error <= 1'b0;
        end else begin
            m0_error <= (state == OWN0) && (sel_read || sel_write) && unmapped;
            m1_error <= (state == OWN1) && (sel_read || sel_write) && unmapped;
        end
    end

    assign bus.m0_grant     = (state == OWN0);
    assign bus.m1_grant     = (state == OWN1);
    assign bus.m0_bus_error = m0_error;
    assign bus.m1_bus_error = m1_error;
    assign bus.address      = sel_address;
    assign bus.data_out     = sel_data;
    assign bus.data_strobes = sel_strobes;
    assign bus.read         = sel_read;
    assign bus.write        = sel_write;
    assign bus.memory_cs    = granted && (region == 8'h00);
    assign bus.display_cs   = granted && (region == 8'hFF);
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised and directed bench for bus_arbiter against a cycle-level ownership model.
// The model's tie-break follows BUS_ARBITER_ROUND_ROBIN_EN when that macro is defined.
module tb_bus_arbiter;
    localparam int MAX_BURST = 4;
`ifdef BUS_ARBITER_ROUND_ROBIN_EN
    localparam bit ROUND_ROBIN = 1'b1;
`else
    localparam bit ROUND_ROBIN = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Model state: owner is -1 for nobody, else the master index
    int       owner;
    int       held;
    int       lastOwner;
    bit [1:0] errPending;
    logic [1:0] grantLog [0:8];

    bus_arbiter_if bus ();

    bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        owner      = -1;
        held       = 0;
        lastOwner  = 1;
        errPending = 2'b00;
    endtask

    task automatic checkCycle();
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        r;
        logic        w;
        logic [7:0]  top;
        a = '0; d = '0; s = '0; r = 1'b0; w = 1'b0;
        if (owner == 0) begin
            a = bus.m0_address; d = bus.m0_data_out; s = bus.m0_data_strobes;
            r = bus.m0_read; w = bus.m0_write;
        end else if (owner == 1) begin
            a = bus.m1_address; d = bus.m1_data_out; s = bus.m1_data_strobes;
            r = bus.m1_read; w = bus.m1_write;
        end
        top = a[29:22];
        checkOutput("m0_grant", 32'(bus.m0_grant), 32'(owner == 0));
        checkOutput("m1_grant", 32'(bus.m1_grant), 32'(owner == 1));
        checkOutput("address", 32'(bus.address), 32'(a));
        checkOutput("data_out", bus.data_out, d);
        checkOutput("data_strobes", 32'(bus.data_strobes), 32'(s));
        checkOutput("read", 32'(bus.read), 32'(r));
        checkOutput("write", 32'(bus.write), 32'(w));
        checkOutput("memory_cs", 32'(bus.memory_cs), 32'(owner >= 0 && top == 8'h00));
        checkOutput("display_cs", 32'(bus.display_cs), 32'(owner >= 0 && top == 8'hFF));
        checkOutput("m0_bus_error", 32'(bus.m0_bus_error), 32'(errPending[0]));
        checkOutput("m1_bus_error", 32'(bus.m1_bus_error), 32'(errPending[1]));
    endtask

    // Advance the model across one rising edge using the inputs currently driven
    task automatic advanceModel();
        bit         r0;
        bit         r1;
        bit         ownerReq;
        bit         otherReq;
        logic       rd;
        logic       wr;
        logic [7:0] top;
        r0 = bus.m0_req;
        r1 = bus.m1_req;
        rd = 1'b0; wr = 1'b0; top = 8'h00;
        if (owner == 0) begin
            rd = bus.m0_read; wr = bus.m0_write; top = bus.m0_address[29:22];
        end else if (owner == 1) begin
            rd = bus.m1_read; wr = bus.m1_write; top = bus.m1_address[29:22];
        end
        errPending = 2'b00;
        if (owner >= 0 && (rd || wr) && top != 8'h00 && top != 8'hFF) errPending[owner] = 1'b1;
        if (owner < 0) begin
            held = 0;
            if (r0 && r1) owner = ROUND_ROBIN ? 1 - lastOwner : 0;
            else if (r0) owner = 0;
            else if (r1) owner = 1;
        end else begin
            ownerReq = (owner == 0) ? r0 : r1;
            otherReq = (owner == 0) ? r1 : r0;
            if (!ownerReq) begin
                owner = otherReq ? 1 - owner : -1;
                held  = 0;
            end else if (otherReq) begin
                held++;
                if (held == MAX_BURST) begin
                    owner = 1 - owner;
                    held  = 0;
                end
            end else begin
                held = 0;
            end
        end
        if (owner >= 0) lastOwner = owner;
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic applyStimulus(
        input bit req0, input bit rd0, input bit wr0, input logic [31:0] addr0,
        input logic [31:0] data0, input logic [3:0] strb0,
        input bit req1, input bit rd1, input bit wr1, input logic [31:0] addr1,
        input logic [31:0] data1, input logic [3:0] strb1);
        bus.m0_req = req0; bus.m0_read = rd0; bus.m0_write = wr0;
        bus.m0_address = addr0[31:2]; bus.m0_data_out = data0; bus.m0_data_strobes = strb0;
        bus.m1_req = req1; bus.m1_read = rd1; bus.m1_write = wr1;
        bus.m1_address = addr1[31:2]; bus.m1_data_out = data1; bus.m1_data_strobes = strb1;
        #1;
        checkCycle();
        advanceModel();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] randAddr();
        logic [31:0] a;
        a = $urandom;
        case ($urandom_range(0, 2))
            0: a[31:24] = 8'h00;
            1: a[31:24] = 8'hFF;
            default: ;
        endcase
        return a;
    endfunction

    initial begin
        resetModel();
        reset = 1'b0;
        bus.m0_req = 1'b1; bus.m0_read = 1'b1; bus.m0_write = 1'b0;
        bus.m0_address = 30'h4; bus.m0_data_out = '0; bus.m0_data_strobes = 4'hF;
        bus.m1_req = 1'b0; bus.m1_read = 1'b0; bus.m1_write = 1'b0;
        bus.m1_address = '0; bus.m1_data_out = '0; bus.m1_data_strobes = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        checkCycle();
        checkOutput("reset grants", 32'({bus.m0_grant, bus.m1_grant}), 32'd0);
        reset = 1'b1;

        // m0 reads memory
        applyStimulus(1, 1, 0, 32'h0000_0010, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        checkOutput("tp m0_grant", 32'(bus.m0_grant), 32'd1);
        checkOutput("tp memory_cs", 32'(bus.memory_cs), 32'd1);
        checkOutput("tp display_cs", 32'(bus.display_cs), 32'd0);
        applyStimulus(1, 1, 0, 32'h0000_0010, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        idleCycles(2);

        // m1 alone writes the display
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hFF00_0000, 32'hDEAD_BEEF, 4'hF);
        checkOutput("tp m1_grant", 32'(bus.m1_grant), 32'd1);
        checkOutput("tp display_cs", 32'(bus.display_cs), 32'd1);
        checkOutput("tp data_out", bus.data_out, 32'hDEAD_BEEF);
        checkOutput("tp write", 32'(bus.write), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hFF00_0000, 32'hDEAD_BEEF, 4'hF);
        idleCycles(2);

        // Continuous contention: 4 cycles m0, 4 cycles m1, no gap
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 1, 0, 32'h0000_0100, 0, 4'h1, 1, 1, 0, 32'hFF00_0004, 0, 4'h2);
            grantLog[i] = {bus.m1_grant, bus.m0_grant};
        end
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("burst slot %0d", i), 32'(grantLog[i]),
                        (i >= 4 && i < 8) ? 32'd2 : 32'd1);
        end

        // m0 drops while m1 requests: handover in the same cycle
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'h0000_0040, 32'h1234_5678, 4'h3);
        checkOutput("handover grants", 32'({bus.m1_grant, bus.m0_grant}), 32'd2);
        idleCycles(1);
        checkOutput("idle address", 32'(bus.address), 32'd0);
        idleCycles(1);

        // Unmapped read by m0
        applyStimulus(1, 1, 0, 32'h4000_0000, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 32'h4000_0000, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        checkOutput("tp m0_bus_error", 32'(bus.m0_bus_error), 32'd1);
        checkOutput("tp m1_bus_error", 32'(bus.m1_bus_error), 32'd0);
        applyStimulus(1, 0, 0, 32'h4000_0000, 0, 4'hF, 0, 0, 0, 0, 0, 0);
        checkOutput("tp error pulse end", 32'(bus.m0_bus_error), 32'd0);
        idleCycles(2);

        // Ties from IDLE, preceded by an m1 transfer so both builds start m0-first
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        idleCycles(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("tie 1 m0_grant", 32'(bus.m0_grant), 32'd1);
        idleCycles(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("tie 2 m0_grant", 32'(bus.m0_grant), ROUND_ROBIN ? 32'd0 : 32'd1);
        checkOutput("tie 2 m1_grant", 32'(bus.m1_grant), ROUND_ROBIN ? 32'd1 : 32'd0);
        idleCycles(2);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), randAddr(),
                          $urandom, 4'($urandom),
                          $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), randAddr(),
                          $urandom, 4'($urandom));
        end

        // Asynchronous reset in the middle of an owned transfer
        applyStimulus(1, 1, 1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1, 1, 0, 32'h7700_0000, 0, 4'hF);
        applyStimulus(1, 1, 1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF, 1, 1, 0, 32'h7700_0000, 0, 4'hF);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async reset grants", 32'({bus.m1_grant, bus.m0_grant}), 32'd0);
        checkOutput("async reset data_out", bus.data_out, 32'd0);
        checkOutput("async reset write", 32'(bus.write), 32'd0);
        checkOutput("async reset memory_cs", 32'(bus.memory_cs), 32'd0);
        resetModel();
        @(negedge clock);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hFF00_0008, 0, 4'hF);
        checkOutput("restart m1_grant", 32'(bus.m1_grant), 32'd1);
        idleCycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
